// File: rtl/keylock_code_datapath.sv
// Keylock digit-entry buffer, code storage and blink sequencer.
// Supplies match/ValidNewUC/DoneBlink to the controller and drives LED1/LEDblink.
module keylock_code_datapath #(
    parameter int          MAX_DIGITS   = 8,
    parameter int          MIN_DIGITS   = 4,
    parameter int          PC_LEN       = 4,
    parameter logic [31:0] PC_CODE      = 32'h0000_1234,
    parameter int          BLINK_CYCLES = 12_500_000,
    parameter int          BLINK_COUNT  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keypress,
    input  logic       rdy,
    input  logic       CheckPC,
    input  logic       LOCKING,
    input  logic       CheckValidUC,
    input  logic       confirmUC,
    input  logic       ToggleLED1,
    input  logic       error,
    input  logic       Chillin,
    output logic       match,
    output logic       ValidNewUC,
    output logic       DoneBlink,
    output logic       LED1,
    output logic       LEDblink,
    output logic [3:0] entry_len
);

    localparam int BW = 4 * MAX_DIGITS;
    localparam int CW = $clog2(BLINK_CYCLES + 1);
    localparam int PW = $clog2(BLINK_COUNT + 1);

    localparam logic [BW-1:0] PC_WORD   = BW'(PC_CODE);
    localparam logic [3:0]    MAX_L     = 4'(MAX_DIGITS);
    localparam logic [3:0]    MIN_L     = 4'(MIN_DIGITS);
    localparam logic [3:0]    PC_L      = 4'(PC_LEN);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BLINK_CYCLES - 1);
    localparam logic [PW-1:0] PAIR_LAST = PW'(BLINK_COUNT - 1);

    typedef enum logic [1:0] {B_IDLE, B_ON, B_OFF, B_DONE} blink_t;

    logic [BW-1:0] buffer, pend_code, uc_code;
    logic [3:0]    pend_len, uc_len;
    logic          ovf, uc_valid;
    logic          is_digit, is_clear, prog_key;

    always_comb begin
        is_digit = (keypress <= 4'd6);
        is_clear = (keypress == 4'd7) || (keypress == 4'd8) || (keypress == 4'd9);
        prog_key = (keypress == 4'd8);
    end

    // Entry buffer: shift in digits, saturate with sticky overflow, clear on 7/8/9
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer    <= '0;
            entry_len <= '0;
            ovf       <= 1'b0;
        end else if (rdy) begin
            if (is_digit) begin
                if (entry_len != MAX_L) begin
                    buffer    <= {buffer[BW-5:0], keypress};
                    entry_len <= entry_len + 4'd1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (is_clear) begin
                buffer    <= '0;
                entry_len <= '0;
                ovf       <= 1'b0;
            end
        end
    end

    // Both code updates see the pre-clear entry and the pre-update pending code
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_code <= '0;
            pend_len  <= '0;
            uc_code   <= '0;
            uc_len    <= '0;
            uc_valid  <= 1'b0;
        end else if (rdy && prog_key) begin
            if (CheckValidUC && ValidNewUC) begin
                pend_code <= buffer;
                pend_len  <= entry_len;
            end
            if (confirmUC && match) begin
                uc_code  <= pend_code;
                uc_len   <= pend_len;
                uc_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        match = 1'b0;
        if (!ovf) begin
            if (CheckPC)
                match = (entry_len == PC_L) && (buffer == PC_WORD);
            else if (LOCKING)
                match = uc_valid && (entry_len == uc_len) && (buffer == uc_code);
            else if (confirmUC)
                match = (entry_len == pend_len) && (buffer == pend_code);
        end
    end

    always_comb begin
        ValidNewUC = !ovf && (entry_len >= MIN_L) && (entry_len <= MAX_L);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            LED1 <= 1'b0;
        else if (ToggleLED1)
            LED1 <= ~LED1;
    end

    logic          trig, trig_d;
    blink_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [PW-1:0] pairs, pairs_nx;

    always_comb begin
        trig = error | Chillin;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= B_IDLE;
            cnt    <= '0;
            pairs  <= '0;
            trig_d <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            pairs  <= pairs_nx;
            trig_d <= trig;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pairs_nx = pairs;
        case (state)
            B_IDLE: begin
                if (trig && !trig_d) begin
                    state_nx = B_ON;
                    cnt_nx   = '0;
                    pairs_nx = '0;
                end
            end
            B_ON: begin
                if (!trig) begin
                    state_nx = B_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nx = B_OFF;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            B_OFF: begin
                if (!trig) begin
                    state_nx = B_IDLE;
                end else if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    pairs_nx = pairs + PW'(1);
                    state_nx = (pairs == PAIR_LAST) ? B_DONE : B_ON;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            B_DONE:  state_nx = B_IDLE;
            default: state_nx = B_IDLE;
        endcase
    end

    always_comb begin
        LEDblink  = (state == B_ON);
        DoneBlink = (state == B_DONE);
    end

endmodule

// File: doc/keylock_code_datapath.md
Name: keylock_code_datapath

Overview:
- Digit-entry and code-storage datapath paired with the keylock `controller` FSM.
- Collects digit keypresses into an entry buffer.
- Produces the `match`, `ValidNewUC` and `DoneBlink` status inputs that the controller consumes.
- Stores the programming code and the user code, and drives the lock-state LED (LED1) and the error/success blink LED.

Parameters:
- MAX_DIGITS, 8: entry buffer depth in digits (4 bits each).
- MIN_DIGITS, 4: minimum length of a valid new user code.
- PC_LEN, 4: programming-code length in digits.
- PC_CODE, 32'h0000_1234: programming code, one digit per nibble, last-entered digit in [3:0].
- BLINK_CYCLES, 12_500_000: clock cycles per blink half-period.
- BLINK_COUNT, 3: number of on/off blink pairs.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- keypress, input, 4: key code. 0-6 are digits, 7 is cancel, 8 is program, 9 is lock.
- rdy, input, 1: keypress valid this cycle (one-cycle strobe per key).
- CheckPC, input, 1: controller mode, compare entry against PC_CODE.
- LOCKING, input, 1: controller mode, compare entry against the user code.
- CheckValidUC, input, 1: controller mode, entry is a candidate new user code.
- confirmUC, input, 1: controller mode, compare entry against the pending code.
- ToggleLED1, input, 1: toggle lock LED.
- error, input, 1: controller in a failure state; starts the blink sequence.
- Chillin, input, 1: controller in the success state; starts the blink sequence.
- match, output, 1: combinational compare result for the current mode.
- ValidNewUC, output, 1: entry length is legal for a new user code.
- DoneBlink, output, 1: one-cycle pulse at the end of the blink sequence.
- LED1, output, 1: lock state, 1 = locked.
- LEDblink, output, 1: blink LED.
- entry_len, output, 4: digits currently buffered, 0..MAX_DIGITS.

Behaviour:
Reset:
- Entry buffer = 0, entry_len = 0, ovf = 0.
- Pending code and user code = 0, uc_valid = 0.
- LED1 = 0, blink FSM in IDLE, LEDblink = 0, DoneBlink = 0.

Entry buffer, when rdy is high:
- Digit key (<=6) with entry_len < MAX_DIGITS: buffer <= {buffer[4*MAX_DIGITS-5:0], keypress}; entry_len increments.
- Digit key with entry_len == MAX_DIGITS: buffer unchanged and entry_len saturates; set sticky ovf.
- Key 7, 8 or 9: buffer, entry_len and ovf clear on that same edge. `match` and `ValidNewUC` are therefore sampled by the controller on pre-clear contents.

match, purely combinational from registers and mode inputs; 0 whenever ovf = 1:
- CheckPC: entry_len == PC_LEN and buffer == PC_CODE.
- LOCKING: uc_valid, entry_len == uc_len and buffer == user code.
- confirmUC: entry_len == pend_len and buffer == pending code.
- Otherwise 0. If several mode inputs are high, priority is CheckPC > LOCKING > confirmUC.

ValidNewUC:
- = !ovf and MIN_DIGITS <= entry_len <= MAX_DIGITS, independent of mode.

Code registers:
- CheckValidUC and rdy and key 8 and ValidNewUC: pending code/length <= buffer/entry_len.
- confirmUC and rdy and key 8 and match: user code/length <= pending; uc_valid <= 1.
- Both updates occur on the same edge as the buffer clear.

LED1:
- Inverts on every rising clk edge where ToggleLED1 = 1.

Blink FSM (states IDLE, ON, OFF, DONE); trig = error | Chillin:
- IDLE -> ON on a rising edge of trig (registered trig_d is 0, trig is 1). Counter and pair count load 0.
- ON: LEDblink = 1. After BLINK_CYCLES cycles -> OFF.
- OFF: after BLINK_CYCLES cycles, pair count increments. If pair count reaches BLINK_COUNT -> DONE, else -> ON.
- DONE: DoneBlink = 1 for exactly one cycle, then -> IDLE.
- trig falling while in ON or OFF: abort to IDLE next edge, LEDblink = 0, no DoneBlink pulse.
- trig held high after DONE does not retrigger; a fresh rising edge is required.

Test Plan:
1. reset=1 mid-entry (3 digits buffered, blink in ON) -> all outputs 0 within the same cycle, entry_len = 0; after release, first digit gives entry_len = 1.
2. Bench parameters BLINK_CYCLES=4, BLINK_COUNT=2. CheckPC high, enter digits 1,2,3,4 -> match = 1. Then key 8 -> next cycle entry_len = 0, match = 0. Entering 1,2,3,5 instead gives match = 0.
3. Programming flow:
   - CheckValidUC, enter 5,6,0,1,2 and key 8 -> pending = 0x56012, pend_len = 5.
   - confirmUC, enter 5,6,0,1,2 and key 8 -> uc_valid = 1.
   - LOCKING, enter 5,6,0,1,2 -> match = 1.
   - LOCKING with uc_valid = 0 -> match = 0 for any entry.
4. Enter 9 digits -> entry_len = 8, ovf = 1, match = 0 and ValidNewUC = 0. Entering 3 digits gives ValidNewUC = 0; 4 digits gives ValidNewUC = 1.
5. error rises and is held -> LEDblink pattern is 4 high / 4 low, repeated twice. DoneBlink is high for 1 cycle at cycle 17 after the trigger edge. No retrigger while error stays high.
6. Chillin rises, then drops after 6 cycles -> FSM returns to IDLE, LEDblink = 0, DoneBlink never asserts. ToggleLED1 held 1 cycle -> LED1 goes 0->1; a second pulse gives 1->0.
